rfifo_fwft_out: RTL

//  Read-side output stage of the asynchronous FIFO, rclk domain, directly downstream of the

---
 rtl/rfifo_fwft_out.sv | 69 ++++++
 1 files changed

// File: rtl/rfifo_fwft_out.sv
// FWFT output stage for the async FIFO read side: turns rempty/rinc plus a 1-cycle
// registered memory read into a valid/ready stream backed by a 2-entry buffer.
module rfifo_fwft_out #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            buf_count
);

  logic [1:0]            count_reg;
  logic [1:0]            count_next;
  logic                  inflight_reg;
  logic                  wr_idx_reg;
  logic                  rd_idx_reg;
  logic [DATA_WIDTH-1:0] entry_reg [2];

  logic       push;
  logic       pop;
  logic [2:0] occupancy;

  assign push      = inflight_reg;
  assign pop       = out_valid & out_ready;
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg};

  // Reserve a slot for every word requested but not yet captured, so the buffer cannot
  // overflow. rinc is gated by rrst because the pointer logic is held in reset as well.
  assign rinc = ~rrst & ~rempty & ((occupancy < 3'd2) | pop);

  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
      wr_idx_reg   <= 1'b0;
      rd_idx_reg   <= 1'b0;
    end else begin
      count_reg    <= count_next;
      inflight_reg <= rinc;
      if (push) wr_idx_reg <= ~wr_idx_reg;
      if (pop)  rd_idx_reg <= ~rd_idx_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
          entry_reg[gi] <= '0;
        end else if (push && (wr_idx_reg == 1'(gi))) begin
          entry_reg[gi] <= rdata;
        end
      end
    end
  endgenerate

  assign out_valid = (count_reg != 2'd0);
  assign out_data  = entry_reg[rd_idx_reg];
  assign buf_count = count_reg;

endmodule
